cskip_adder_pipe: RTL

CSKIP_ADDER_PIPE -- requirements
Module: cskip_adder_pipe

---
 rtl/cskip_adder_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cskip_adder_pipe.sv
// cskip_adder_pipe: carry-skip adder pipelined one block per stage, with
// valid/ready flow control. Optional overflow output under CSKIP_ADDER_OVF_EN.
`timescale 1ns/1ps
module cskip_adder_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned BLOCK = 4,
   localparam int unsigned NBLK = (BLOCK >= 1) ? WIDTH / BLOCK : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [NBLK-1:0]  skip
`ifdef CSKIP_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned BW   = BLOCK + 1;
   localparam int unsigned BDIV = (BLOCK >= 1) ? BLOCK : 1;

   // Reject configurations that do not split evenly into blocks
   if ((BLOCK < 1) || ((WIDTH % BDIV) != 0)) begin : g_bad_cfg
      $error("cskip_adder_pipe: BLOCK must be >= 1 and divide WIDTH");
   end

   // Stage registers: index k holds the state produced by stage k
   logic             v_q [NBLK];
   logic             c_q [NBLK];
   logic [WIDTH-1:0] a_q [NBLK];
   logic [WIDTH-1:0] b_q [NBLK];
   logic [WIDTH-1:0] s_q [NBLK];
   logic [NBLK-1:0]  k_q [NBLK];
   logic             am_q [NBLK];
   logic             bm_q [NBLK];

   // Stage inputs (previous stage registers, or ports for stage 0)
   logic             v_p [NBLK];
   logic             c_p [NBLK];
   logic [WIDTH-1:0] a_p [NBLK];
   logic [WIDTH-1:0] b_p [NBLK];
   logic [WIDTH-1:0] s_p [NBLK];
   logic [NBLK-1:0]  k_p [NBLK];
   logic             am_p [NBLK];
   logic             bm_p [NBLK];

   // Stage next values
   logic             v_n [NBLK];
   logic             c_n [NBLK];
   logic [WIDTH-1:0] a_n [NBLK];
   logic [WIDTH-1:0] b_n [NBLK];
   logic [WIDTH-1:0] s_n [NBLK];
   logic [NBLK-1:0]  k_n [NBLK];

   logic [BLOCK-1:0] prop [NBLK];
   logic [BLOCK:0]   rip  [NBLK];
   logic             en;

   assign en       = out_ready | ~v_q[NBLK-1];
   assign in_ready = en;

   // Select each stage's source: ports for stage 0, previous stage otherwise
   always_comb begin
      v_p[0]  = in_valid;
      c_p[0]  = cin;
      a_p[0]  = a;
      b_p[0]  = b;
      s_p[0]  = '0;
      k_p[0]  = '0;
      am_p[0] = a[WIDTH-1];
      bm_p[0] = b[WIDTH-1];
      for (int k = 1; k < NBLK; k++) begin
         v_p[k]  = v_q[k-1];
         c_p[k]  = c_q[k-1];
         a_p[k]  = a_q[k-1];
         b_p[k]  = b_q[k-1];
         s_p[k]  = s_q[k-1];
         k_p[k]  = k_q[k-1];
         am_p[k] = am_q[k-1];
         bm_p[k] = bm_q[k-1];
      end
   end

   // Per-stage block add; operands are shifted so each stage sees its block in the low bits
   always_comb begin
      for (int k = 0; k < NBLK; k++) begin
         prop[k] = a_p[k][BLOCK-1:0] ^ b_p[k][BLOCK-1:0];
         rip[k]  = ({1'b0, a_p[k][BLOCK-1:0]} + {1'b0, b_p[k][BLOCK-1:0]}) + BW'(c_p[k]);
         v_n[k]  = v_p[k];
         a_n[k]  = a_p[k] >> BLOCK;
         b_n[k]  = b_p[k] >> BLOCK;
         s_n[k]  = s_p[k];
         s_n[k][k*BLOCK +: BLOCK] = rip[k][BLOCK-1:0];
         k_n[k]  = k_p[k];
         k_n[k][k] = &prop[k];
         c_n[k]  = (&prop[k]) ? c_p[k] : rip[k][BLOCK];
      end
   end

   // Pipeline registers; the whole pipe advances together or holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NBLK; k++) begin
            v_q[k]  <= 1'b0;
            c_q[k]  <= 1'b0;
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            s_q[k]  <= '0;
            k_q[k]  <= '0;
            am_q[k] <= 1'b0;
            bm_q[k] <= 1'b0;
         end
      end else if (en) begin
         for (int k = 0; k < NBLK; k++) begin
            v_q[k]  <= v_n[k];
            c_q[k]  <= c_n[k];
            a_q[k]  <= a_n[k];
            b_q[k]  <= b_n[k];
            s_q[k]  <= s_n[k];
            k_q[k]  <= k_n[k];
            am_q[k] <= am_p[k];
            bm_q[k] <= bm_p[k];
         end
      end
   end

   assign out_valid = v_q[NBLK-1];
   assign sum       = s_q[NBLK-1];
   assign cout      = c_q[NBLK-1];
   assign skip      = k_q[NBLK-1];

`ifdef CSKIP_ADDER_OVF_EN
   logic ovf_n;
   logic ovf_q;

   // Signed overflow: like-signed operands produce an opposite-signed sum
   always_comb begin
      ovf_n = (am_p[NBLK-1] == bm_p[NBLK-1]) && (s_n[NBLK-1][WIDTH-1] != am_p[NBLK-1]);
   end

   // Overflow flag travels with the final stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_n;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule
